// File: rtl/alu_issue_if.sv
// Issue-stage bundle: upstream instruction/operand handshake plus the ALU-side issue outputs.
// The master modport belongs to whoever drives instructions in and consumes issue results.
interface alu_issue_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int CNT_WIDTH     = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              instr;
  logic [DATA_WIDTH-1:0]    rs1_data;
  logic [DATA_WIDTH-1:0]    rs2_data;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [4:0]               rd;
  logic                     reg_write;
  logic                     illegal;
  logic [CNT_WIDTH-1:0]     illegal_cnt;

  modport master (
    output in_valid, instr, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, Operation, SrcA, SrcB, rd, reg_write, illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, instr, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, Operation, SrcA, SrcB, rd, reg_write, illegal, illegal_cnt
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Registered RV32 decode/issue stage feeding the ALU: one-cycle latency, full throughput,
// outputs held while the ALU stalls; flush kills both the held and the incoming instruction.
module alu_issue_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_issue_if.slave   bus
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND   = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR   = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD   = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLLI  = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRAI  = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQUAL = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT   = OPCODE_LENGTH'(4'b1100);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opc = bus.instr[6:0];
  assign f3  = bus.instr[14:12];
  assign f7  = bus.instr[31:25];

  logic [DATA_WIDTH-1:0] imm_i, imm_s, shamt;
  assign imm_i = {{(DATA_WIDTH-12){bus.instr[31]}}, bus.instr[31:20]};
  assign imm_s = {{(DATA_WIDTH-12){bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign shamt = {{(DATA_WIDTH-5){1'b0}}, bus.instr[24:20]};

  // Shared funct3 -> ALU op mapping used by both R-type and I-type arithmetic.
  logic                     f3_ok;
  logic [OPCODE_LENGTH-1:0] f3_op;
  always_comb begin
    f3_ok = 1'b1;
    f3_op = OP_AND;
    case (f3)
      3'b000:  f3_op = OP_ADD;
      3'b111:  f3_op = OP_AND;
      3'b100:  f3_op = OP_XOR;
      3'b010:  f3_op = OP_SLT;
      default: f3_ok = 1'b0;
    endcase
  end

  logic [OPCODE_LENGTH-1:0] op_d;
  logic [DATA_WIDTH-1:0]    srcb_d;
  logic                     reg_write_d;
  logic                     illegal_d;

  always_comb begin
    op_d        = OP_AND;
    srcb_d      = bus.rs2_data;
    reg_write_d = 1'b0;
    illegal_d   = 1'b1;
    case (opc)
      OPC_R: begin
        if (f7 == 7'b0000000 && f3_ok) begin
          op_d        = f3_op;
          reg_write_d = 1'b1;
          illegal_d   = 1'b0;
        end
      end
      OPC_I: begin
        if (f3_ok) begin
          op_d        = f3_op;
          srcb_d      = imm_i;
          reg_write_d = 1'b1;
          illegal_d   = 1'b0;
        end else if (f3 == 3'b001 && f7 == 7'b0000000) begin
          op_d        = OP_SLLI;
          srcb_d      = shamt;
          reg_write_d = 1'b1;
          illegal_d   = 1'b0;
        end else if (f3 == 3'b101 && f7 == 7'b0100000) begin
          op_d        = OP_SRAI;
          srcb_d      = shamt;
          reg_write_d = 1'b1;
          illegal_d   = 1'b0;
        end
      end
      OPC_LOAD: begin
        if (f3 == 3'b010) begin
          op_d        = OP_ADD;
          srcb_d      = imm_i;
          reg_write_d = 1'b1;
          illegal_d   = 1'b0;
        end
      end
      OPC_STORE: begin
        if (f3 == 3'b010) begin
          op_d      = OP_ADD;
          srcb_d    = imm_s;
          illegal_d = 1'b0;
        end
      end
      OPC_BRANCH: begin
        if (f3 == 3'b000) begin
          op_d      = OP_EQUAL;
          illegal_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  logic                     out_valid_q, out_valid_d;
  logic [OPCODE_LENGTH-1:0] op_q;
  logic [DATA_WIDTH-1:0]    srca_q, srcb_q;
  logic [4:0]               rd_q;
  logic                     reg_write_q, illegal_q;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic                     in_ready, accept;

  assign in_ready = !bus.flush && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    if (bus.flush)          out_valid_d = 1'b0;
    else if (accept)        out_valid_d = 1'b1;
    else if (bus.out_ready) out_valid_d = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && illegal_d && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      op_q        <= '0;
      srca_q      <= '0;
      srcb_q      <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      if (accept) begin
        op_q        <= op_d;
        srca_q      <= bus.rs1_data;
        srcb_q      <= srcb_d;
        rd_q        <= bus.instr[11:7];
        reg_write_q <= reg_write_d;
        illegal_q   <= illegal_d;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.Operation   = op_q;
  assign bus.SrcA        = srca_q;
  assign bus.SrcB        = srcb_q;
  assign bus.rd          = rd_q;
  assign bus.reg_write   = reg_write_q;
  assign bus.illegal     = illegal_q;
  assign bus.illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed spec scenarios plus randomized traffic scored against a behavioural decode model.
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_if bus();
  alu_issue_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int n_pass = 0;
  int n_total = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] srcb;
    logic        rw;
    logic        ill;
  } exp_t;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SRAI = 32'h40335293;
  localparam logic [31:0] I_ADDI = 32'hFFF00093;
  localparam logic [31:0] I_SUB  = 32'h40208133;

  // Reference decode written from the instruction-set rules, not the RTL structure.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs2);
    exp_t r;
    int alu;
    logic [31:0] i_imm, s_imm;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    i_imm = 32'($signed(ins) >>> 20);
    s_imm = 32'($signed({ins[31:25], ins[11:7], 20'h0}) >>> 20);
    case (f3)
      3'd0: alu = 2;
      3'd7: alu = 0;
      3'd4: alu = 1;
      3'd2: alu = 12;
      default: alu = -1;
    endcase
    r = '{op: 4'd0, srcb: rs2, rw: 1'b0, ill: 1'b1};
    if (opc == 7'h33 && f7 == 0 && alu >= 0)
      r = '{op: 4'(alu), srcb: rs2, rw: 1'b1, ill: 1'b0};
    else if (opc == 7'h13 && alu >= 0)
      r = '{op: 4'(alu), srcb: i_imm, rw: 1'b1, ill: 1'b0};
    else if (opc == 7'h13 && f3 == 1 && f7 == 7'h00)
      r = '{op: 4'd4, srcb: 32'(ins[24:20]), rw: 1'b1, ill: 1'b0};
    else if (opc == 7'h13 && f3 == 5 && f7 == 7'h20)
      r = '{op: 4'd7, srcb: 32'(ins[24:20]), rw: 1'b1, ill: 1'b0};
    else if (opc == 7'h03 && f3 == 2)
      r = '{op: 4'd2, srcb: i_imm, rw: 1'b1, ill: 1'b0};
    else if (opc == 7'h23 && f3 == 2)
      r = '{op: 4'd2, srcb: s_imm, rw: 1'b0, ill: 1'b0};
    else if (opc == 7'h63 && f3 == 0)
      r = '{op: 4'd8, srcb: rs2, rw: 1'b0, ill: 1'b0};
    return r;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0] opcs [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h00};
    logic [6:0] opc, f7;
    logic [31:0] w;
    opc = opcs[$urandom_range(0, 5)];
    if (opc == 7'h00) opc = 7'($urandom);
    case ($urandom_range(0, 2))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    w = $urandom;
    w[6:0] = opc;
    w[31:25] = f7;
    return w;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic fl, input logic ordy);
    bus.in_valid = v;
    bus.instr = ins;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.flush = fl;
    bus.out_ready = ordy;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.Operation !== 4'd0) $display("FAIL reset_op got %h want 0", bus.Operation); else n_pass++;
    n_total++; if (bus.SrcA !== 32'd0 || bus.SrcB !== 32'd0) $display("FAIL reset_src got %h/%h want 0/0", bus.SrcA, bus.SrcB); else n_pass++;
    n_total++; if (bus.rd !== 5'd0 || bus.reg_write !== 1'b0 || bus.illegal !== 1'b0) $display("FAIL reset_ctl got rd=%0d rw=%b ill=%b want 0", bus.rd, bus.reg_write, bus.illegal); else n_pass++;
    n_total++; if (bus.illegal_cnt !== 8'd0) $display("FAIL reset_cnt got %0d want 0", bus.illegal_cnt); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    drive(1, I_ADD, 32'd5, 32'd7, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    n_total++; if (bus.out_valid !== 1'b1) $display("FAIL add_valid got %b want 1", bus.out_valid); else n_pass++;
    n_total++; if (bus.Operation !== 4'b0010) $display("FAIL add_op got %b want 0010", bus.Operation); else n_pass++;
    n_total++; if (bus.SrcA !== 32'd5 || bus.SrcB !== 32'd7) $display("FAIL add_src got %0d/%0d want 5/7", bus.SrcA, bus.SrcB); else n_pass++;
    n_total++; if (bus.rd !== 5'd3 || bus.reg_write !== 1'b1) $display("FAIL add_wb got rd=%0d rw=%b want 3/1", bus.rd, bus.reg_write); else n_pass++;
  endtask

  task automatic test_imm();
    drive(1, I_SRAI, 32'h80000000, 32'd99, 0, 1);
    @(negedge clk);
    n_total++; if (bus.Operation !== 4'b0111 || bus.SrcB !== 32'd3) $display("FAIL srai got op=%b srcb=%h want 0111/3", bus.Operation, bus.SrcB); else n_pass++;
    n_total++; if (bus.rd !== 5'd5 || bus.reg_write !== 1'b1 || bus.illegal !== 1'b0) $display("FAIL srai_ctl got rd=%0d rw=%b ill=%b want 5/1/0", bus.rd, bus.reg_write, bus.illegal); else n_pass++;
    drive(1, I_ADDI, 32'd0, 32'd99, 0, 1);
    @(negedge clk);
    n_total++; if (bus.Operation !== 4'b0010 || bus.SrcB !== 32'hFFFFFFFF) $display("FAIL addi got op=%b srcb=%h want 0010/ffffffff", bus.Operation, bus.SrcB); else n_pass++;
    n_total++; if (bus.rd !== 5'd1) $display("FAIL addi_rd got %0d want 1", bus.rd); else n_pass++;
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
  endtask

  task automatic test_hold();
    drive(1, I_ADD, 32'd11, 32'd22, 0, 1);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      drive(1, I_ADDI, 32'd99, 32'd99, 0, 0);
      #1;
      n_total++; if (bus.in_ready !== 1'b0) $display("FAIL hold_in_ready cyc %0d got %b want 0", c, bus.in_ready); else n_pass++;
      @(negedge clk);
      n_total++; if (bus.out_valid !== 1'b1 || bus.SrcA !== 32'd11 || bus.SrcB !== 32'd22 || bus.Operation !== 4'b0010 || bus.rd !== 5'd3)
        $display("FAIL hold_stable cyc %0d got v=%b a=%0d b=%0d op=%b rd=%0d want 1/11/22/0010/3", c, bus.out_valid, bus.SrcA, bus.SrcB, bus.Operation, bus.rd);
      else n_pass++;
    end
    drive(1, I_ADDI, 32'd99, 32'd99, 0, 1);
    @(negedge clk);
    n_total++; if (bus.out_valid !== 1'b1 || bus.SrcA !== 32'd99 || bus.SrcB !== 32'hFFFFFFFF) $display("FAIL hold_release got v=%b a=%0d b=%h want 1/99/ffffffff", bus.out_valid, bus.SrcA, bus.SrcB); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h00200033 | (32'(i + 1) << 7), 32'(i * 3), 32'(i), 0, 1);
      @(negedge clk);
      n_total++; if (bus.out_valid !== 1'b1 || bus.rd !== 5'(i + 1) || bus.SrcA !== 32'(i * 3) || bus.SrcB !== 32'(i))
        $display("FAIL b2b item %0d got v=%b rd=%0d a=%0d b=%0d want 1/%0d/%0d/%0d", i, bus.out_valid, bus.rd, bus.SrcA, bus.SrcB, i + 1, i * 3, i);
      else n_pass++;
    end
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL drain got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_illegal_sat();
    reset_pulse();
    for (int i = 0; i < 260; i++) begin
      drive(1, I_SUB, 32'd1, 32'd2, 0, 1);
      @(negedge clk);
      if (i == 99) begin
        n_total++; if (bus.illegal_cnt !== 8'd100) $display("FAIL cnt_mid got %0d want 100", bus.illegal_cnt); else n_pass++;
      end
    end
    n_total++; if (bus.illegal_cnt !== 8'd255) $display("FAIL cnt_sat got %0d want 255", bus.illegal_cnt); else n_pass++;
    n_total++; if (bus.illegal !== 1'b1 || bus.reg_write !== 1'b0 || bus.Operation !== 4'b0000)
      $display("FAIL sub_decode got ill=%b rw=%b op=%b want 1/0/0000", bus.illegal, bus.reg_write, bus.Operation);
    else n_pass++;
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
  endtask

  task automatic test_flush();
    reset_pulse();
    drive(1, I_SUB, 0, 0, 0, 1);
    @(negedge clk);
    n_total++; if (bus.out_valid !== 1'b1 || bus.illegal_cnt !== 8'd1) $display("FAIL flush_pre got v=%b cnt=%0d want 1/1", bus.out_valid, bus.illegal_cnt); else n_pass++;
    drive(1, I_SUB, 0, 0, 1, 0);
    #1;
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready got %b want 0", bus.in_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.out_valid !== 1'b0 || bus.illegal_cnt !== 8'd1) $display("FAIL flush_post got v=%b cnt=%0d want 0/1", bus.out_valid, bus.illegal_cnt); else n_pass++;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_idle got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_random();
    logic m_valid;
    exp_t m_e;
    logic [31:0] m_a;
    logic [4:0] m_rd;
    int m_cnt;
    logic v, fl, ordy, exp_rdy, acc;
    logic [31:0] ins, a, b;
    reset_pulse();
    m_valid = 0; m_e = '0; m_a = 0; m_rd = 0; m_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      v = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 19) == 0);
      ordy = ($urandom_range(0, 9) < 7);
      ins = gen_instr();
      a = $urandom;
      b = $urandom;
      drive(v, ins, a, b, fl, ordy);
      #1;
      exp_rdy = !fl && (!m_valid || ordy);
      n_total++; if (bus.in_ready !== exp_rdy) $display("FAIL rnd_in_ready cyc %0d got %b want %b", c, bus.in_ready, exp_rdy); else n_pass++;
      acc = v && exp_rdy;
      if (fl) m_valid = 0;
      else if (acc) begin
        m_valid = 1;
        m_e = ref_decode(ins, b);
        m_a = a;
        m_rd = ins[11:7];
        if (m_e.ill && m_cnt < 255) m_cnt++;
      end else if (ordy) m_valid = 0;
      @(negedge clk);
      n_total++; if (bus.out_valid !== m_valid || bus.illegal_cnt !== 8'(m_cnt))
        $display("FAIL rnd_state cyc %0d got v=%b cnt=%0d want %b/%0d", c, bus.out_valid, bus.illegal_cnt, m_valid, m_cnt);
      else n_pass++;
      if (m_valid) begin
        n_total++; if (bus.Operation !== m_e.op || bus.illegal !== m_e.ill || bus.reg_write !== m_e.rw || bus.rd !== m_rd || bus.SrcA !== m_a || (!m_e.ill && bus.SrcB !== m_e.srcb))
          $display("FAIL rnd_issue cyc %0d instr=%h got op=%b ill=%b rw=%b rd=%0d a=%h b=%h want %b/%b/%b/%0d/%h/%h", c, bus.instr, bus.Operation, bus.illegal, bus.reg_write, bus.rd, bus.SrcA, bus.SrcB, m_e.op, m_e.ill, m_e.rw, m_rd, m_a, m_e.srcb);
        else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset();
    reset_pulse();
    drive(1, I_SUB, 32'd4, 32'd4, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    n_total++; if (bus.out_valid !== 1'b1 || bus.illegal_cnt !== 8'd1) $display("FAIL areset_pre got v=%b cnt=%0d want 1/1", bus.out_valid, bus.illegal_cnt); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (bus.out_valid !== 1'b0 || bus.illegal_cnt !== 8'd0 || bus.SrcA !== 32'd0)
      $display("FAIL areset got v=%b cnt=%0d a=%h want 0/0/0", bus.out_valid, bus.illegal_cnt, bus.SrcA);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_hold();
    test_back_to_back();
    test_illegal_sat();
    test_flush();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
